// File: rtl/serial_seq_tx.sv
// Serial stimulus transmitter: frames a WIDTH-bit word with a downstream reset
// pulse, then shifts it out MSB-first with optional per-cycle hold.
module serial_seq_tx #(
    parameter int WIDTH      = 32,
    parameter int RST_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     load_ready,
    input  logic                     hold,
    output logic                     seq_rst,
    output logic                     x_out,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IDXW = $clog2(WIDTH);
    localparam int CNTW = $clog2(RST_CYCLES + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RSTP,
        SHIFT,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   bit_idx_q, bit_idx_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // The bit on x_out is always shreg_q[WIDTH-1]; bit_idx stops at 0 so it cannot wrap.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
                    state_d = RSTP;
                end
            end
            RSTP: begin
                if (cnt_q == CNT_LAST) begin
                    bit_idx_d = LAST_IDX;
                    state_d   = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (bit_idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        shreg_d   = shreg_q << 1;
                        bit_idx_d = bit_idx_q - IDXW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; load_ready is additionally masked during reset.
    assign load_ready = rst && (state_q == IDLE);
    assign seq_rst    = (state_q == RSTP);
    assign x_valid    = (state_q == SHIFT);
    assign x_out      = (state_q == SHIFT) && shreg_q[WIDTH-1];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign bit_idx    = bit_idx_q;

endmodule
